// File: rtl/md_unit_sched_pkg.sv
// Shared op encodings, FSM states and result type for the multiply/divide sequencer.
package md_unit_sched_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} md_state_e;

  // hold: the op completes but must leave HI/LO untouched
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hold;
  } md_res_t;

  function automatic logic is_arith_op(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_sched_if.sv
// Request/result bundle between the execute stage and the multiply/divide sequencer.
interface md_unit_sched_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, rs_val, rt_val,
                  input  busy, done, hi, lo);
  modport slave  (input  start, md_op, rs_val, rt_val,
                  output busy, done, hi, lo);
endinterface

// File: rtl/md_unit_sched_calc.sv
// Combinational 64-bit product / quotient+remainder for MULT, MULTU, DIV, DIVU.
// Divide-by-zero result selected by MD_DIVZERO_HOLD_EN.
module md_unit_sched_calc
  import md_unit_sched_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output md_res_t     res_o
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, q_u, r_u, q_mag, r_mag;
  logic        div_zero;

  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};

  // Signed divide via magnitudes so -2^31 / -1 wraps deterministically
  assign mag_a    = a_i[31] ? -a_i : a_i;
  assign mag_b    = b_i[31] ? -b_i : b_i;
  assign div_zero = (b_i == 32'd0);
  assign q_u      = div_zero ? 32'd0 : a_i / b_i;
  assign r_u      = div_zero ? 32'd0 : a_i % b_i;
  assign q_mag    = div_zero ? 32'd0 : mag_a / mag_b;
  assign r_mag    = div_zero ? 32'd0 : mag_a % mag_b;

  always_comb begin
    res_o = '0;
    case (op_i)
      MD_MULT:  begin res_o.hi = prod_s[63:32]; res_o.lo = prod_s[31:0]; end
      MD_MULTU: begin res_o.hi = prod_u[63:32]; res_o.lo = prod_u[31:0]; end
      MD_DIV, MD_DIVU: begin
        if (div_zero) begin
`ifdef MD_DIVZERO_HOLD_EN
          res_o.hold = 1'b1;
`else
          res_o.hi = a_i;
          res_o.lo = '1;
`endif
        end else if (op_i == MD_DIV) begin
          res_o.lo = (a_i[31] ^ b_i[31]) ? -q_mag : q_mag;
          res_o.hi = a_i[31] ? -r_mag : r_mag;
        end else begin
          res_o.lo = q_u;
          res_o.hi = r_u;
        end
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/md_unit_sched.sv
// Multiply/divide sequencer: fixed-latency down-counter, owns HI/LO, drives busy/done.
// Optional MD_DIVZERO_HOLD_EN: divide by zero completes in one cycle leaving HI/LO unchanged.
module md_unit_sched
  import md_unit_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  md_unit_sched_if.slave  md
);

  localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_hold_q, pend_hold_d;

  md_res_t          calc_res;
  logic             last_cyc, launch;
  logic [CNT_W-1:0] lat;

  md_unit_sched_calc u_calc (
    .op_i  (md.md_op),
    .a_i   (md.rs_val),
    .b_i   (md.rt_val),
    .res_o (calc_res)
  );

  // A new arithmetic op may issue from IDLE or on the completing edge of the current one
  assign last_cyc = (state_q == ST_RUN) && (cnt_q == CNT_ONE);
  assign launch   = md.start && is_arith_op(md.md_op) && ((state_q == ST_IDLE) || last_cyc);
  assign lat      = calc_res.hold ? CNT_ONE : (is_mult_op(md.md_op) ? MULT_N : DIV_N);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_hold_q <= pend_hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_hold_d = pend_hold_q;

    case (state_q)
      ST_IDLE: begin
        if (md.start && md.md_op == MD_MTHI)      hi_d = md.rs_val;
        else if (md.start && md.md_op == MD_MTLO) lo_d = md.rs_val;
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (last_cyc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (!pend_hold_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d     = ST_RUN;
      cnt_d       = lat;
      pend_hi_d   = calc_res.hi;
      pend_lo_d   = calc_res.lo;
      pend_hold_d = calc_res.hold;
    end
  end

  assign md.busy = (state_q == ST_RUN);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit_sched.sv
// Scoreboard bench for md_unit_sched: reference model queues expected completions,
// monitor pops on every done pulse and checks result and completion cycle.
module tb_md_unit_sched;
  import md_unit_sched_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  md_unit_sched_if md ();

  md_unit_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t scb[$];
  int n_cmp = 0, n_bad = 0;
  int busy_acc = 0, done_acc = 0;

  // Reference state: remaining busy cycles, committed and pending HI/LO
  int          rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output bit hold);
    longint sa, sbv, p, q, r;
    longint unsigned ua, ub, pu;
    sa = $signed(a); sbv = $signed(b); ua = a; ub = b;
    h = 0; l = 0; hold = 0;
    if ((op == MD_DIV || op == MD_DIVU) && b == 0) begin
`ifdef MD_DIVZERO_HOLD_EN
      hold = 1;
`else
      h = a; l = 32'hFFFF_FFFF;
`endif
    end else begin
      case (op)
        MD_MULT:  begin p = sa * sbv; h = p[63:32]; l = p[31:0]; end
        MD_MULTU: begin pu = ua * ub; h = pu[63:32]; l = pu[31:0]; end
        MD_DIV:   begin q = sa / sbv; r = sa % sbv; l = q[31:0]; h = r[31:0]; end
        MD_DIVU:  begin l = a / b; h = a % b; end
        default:  ;
      endcase
    end
  endfunction

  // Effect of the upcoming rising edge on the reference model
  function automatic void model_edge(input bit st, input logic [2:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
    bit free, idle, hold;
    logic [31:0] h, l;
    exp_t e;
    free = (rem <= 1);
    idle = (rem == 0);
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end
    if (st && op <= MD_DIVU && free) begin
      ref_calc(op, a, b, h, l, hold);
      if (hold) begin rem = 1; h = m_hi; l = m_lo; end
      else rem = (op <= MD_MULTU) ? MULT_N : DIV_N;
      m_phi = h; m_plo = l;
      e.hi = h; e.lo = l; e.due = cyc + 1 + rem;
      scb.push_back(e);
    end else if (st && idle && op == MD_MTHI) m_hi = a;
    else if (st && idle && op == MD_MTLO) m_lo = a;
  endfunction

  task automatic drive(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md.start = st; md.md_op = op; md.rs_val = a; md.rt_val = b;
    model_edge(st, op, a, b);
    @(negedge clk);
    if (md.busy) busy_acc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 3'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && md.done) begin
      done_acc++;
      if (scb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_done: done at cycle %0d with no result expected", cyc);
      end else begin
        e = scb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.due));
        check("done_hi", 64'(md.hi), 64'(e.hi));
        check("done_lo", 64'(md.lo), 64'(e.lo));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    md.start = 0; md.md_op = 0; md.rs_val = 0; md.rt_val = 0;
    @(negedge clk);
    check("rst_busy", 64'(md.busy), 64'd0);
    check("rst_done", 64'(md.done), 64'd0);
    check("rst_hi", 64'(md.hi), 64'd0);
    check("rst_lo", 64'(md.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    busy_acc = 0;
    drive(1, MD_MULT, 32'd3, 32'hFFFF_FFFE);
    idle(MULT_N + 1);
    check("mult_busy_len", 64'(busy_acc), 64'(MULT_N));
    check("mult_hi", 64'(md.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(md.lo), 64'hFFFF_FFFA);

    drive(1, MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    idle(MULT_N + 1);
    check("multu_hi", 64'(md.hi), 64'h1);
    check("multu_lo", 64'(md.lo), 64'hFFFF_FFFE);

    busy_acc = 0;
    drive(1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(DIV_N + 1);
    check("div_busy_len", 64'(busy_acc), 64'(DIV_N));
    check("div_hi", 64'(md.hi), 64'hFFFF_FFFF);
    check("div_lo", 64'(md.lo), 64'hFFFF_FFFD);

    drive(1, MD_DIVU, 32'd7, 32'd2);
    idle(DIV_N + 1);
    check("divu_hi", 64'(md.hi), 64'd1);
    check("divu_lo", 64'(md.lo), 64'd3);

    drive(1, MD_MTHI, 32'd1234, 32'd0);
    check("mthi_hi", 64'(md.hi), 64'd1234);
    check("mthi_busy", 64'(md.busy), 64'd0);

    drive(1, MD_DIV, 32'd100, 32'd7);
    drive(1, MD_MTLO, 32'd55, 32'd0);
    check("mtlo_ignored_lo", 64'(md.lo), 64'd3);
    idle(DIV_N);
    check("div2_hi", 64'(md.hi), 64'd2);
    check("div2_lo", 64'(md.lo), 64'd14);

    busy_acc = 0;
    drive(1, MD_DIVU, 32'd5, 32'd0);
    idle(DIV_N + 1);
`ifdef MD_DIVZERO_HOLD_EN
    check("div0_busy_len", 64'(busy_acc), 64'd1);
    check("div0_hi", 64'(md.hi), 64'd2);
    check("div0_lo", 64'(md.lo), 64'd14);
`else
    check("div0_busy_len", 64'(busy_acc), 64'(DIV_N));
    check("div0_hi", 64'(md.hi), 64'd5);
    check("div0_lo", 64'(md.lo), 64'hFFFF_FFFF);
`endif

    busy_acc = 0;
    drive(1, MD_MULT, 32'd6, 32'd7);
    idle(MULT_N - 1);
    drive(1, MD_MULTU, 32'd2, 32'd3);
    check("b2b_done", 64'(md.done), 64'd1);
    check("b2b_busy", 64'(md.busy), 64'd1);
    check("b2b_first_lo", 64'(md.lo), 64'd42);
    idle(MULT_N + 1);
    check("b2b_busy_len", 64'(busy_acc), 64'(2 * MULT_N));
    check("b2b_second_lo", 64'(md.lo), 64'd6);

    drive(1, MD_MULT, 32'd9, 32'd9);
    idle(2);
    reset = 1'b1;
    scb.delete();
    rem = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
    #1;
    check("midrst_busy", 64'(md.busy), 64'd0);
    check("midrst_done", 64'(md.done), 64'd0);
    check("midrst_hi", 64'(md.hi), 64'd0);
    check("midrst_lo", 64'(md.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    d0 = done_acc;
    idle(MULT_N + 8);
    check("no_late_done", 64'(done_acc - d0), 64'd0);

    for (int i = 0; i < 600; i++) begin
      drive(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_val(), rnd_val());
      if (rem == 0 && ($urandom_range(0, 15) == 0)) begin
        check("rand_hi", 64'(md.hi), 64'(m_hi));
        check("rand_lo", 64'(md.lo), 64'(m_lo));
      end
    end
    idle(DIV_N + 2);
    check("scb_drained", 64'(scb.size()), 64'd0);
    check("final_hi", 64'(md.hi), 64'(m_hi));
    check("final_lo", 64'(md.lo), 64'(m_lo));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
